// File: rtl/eae_unit_pkg.sv
// Shared definitions for the PDP-8 Extended Arithmetic Element (MUY/DVI).
// Operation select, FSM state encoding and the fixed PDP-8 word width.
package eae_unit_pkg;

    localparam int EAE_WIDTH = 12;

    typedef enum logic {
        EAE_MUY = 1'b0,
        EAE_DVI = 1'b1
    } eae_op_t;

    typedef enum logic [1:0] {
        EAE_IDLE = 2'd0,
        EAE_RUN  = 2'd1,
        EAE_DONE = 2'd2
    } eae_state_t;

endpackage

// File: rtl/eae_unit.sv
// PDP-8 EAE: iterative shift-add multiply (MUY) and restoring divide (DVI),
// one operand bit per clock, sharing one counter, one FSM and one work register pair.
module eae_unit
    import eae_unit_pkg::*;
#(
    parameter int WIDTH = EAE_WIDTH
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             start,
    input  eae_op_t          op,
    input  logic [WIDTH-1:0] ac_in,
    input  logic [WIDTH-1:0] mq_in,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ac_mul,
    output logic [WIDTH-1:0] mq_mul,
    output logic [WIDTH-1:0] ac_dvi,
    output logic [WIDTH-1:0] mq_dvi,
    output logic             link_dvi
);

    localparam int CW = $clog2(WIDTH + 1);

    eae_state_t       state;
    eae_state_t       state_next;
    logic [CW-1:0]    count;
    eae_op_t          op_q;
    logic [WIDTH-1:0] divisor_q;

    // hi_q: MUY accumulator / DVI partial remainder (one bit wider than a word).
    // lo_q: MUY multiplier being consumed / DVI quotient being built.
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             dvi_overflow;
    logic             last_iter;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   mul_hi_next;
    logic [WIDTH-1:0] mul_lo_next;

    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH:0]   div_hi_next;
    logic [WIDTH-1:0] div_q_next;

    // A quotient that would not fit in one word is caught before any iteration.
    assign dvi_overflow = (op == EAE_DVI) && (ac_in >= operand);
    assign last_iter    = (state == EAE_RUN) && (count == CW'(1));

    assign busy = (state != EAE_IDLE);
    assign done = (state == EAE_DONE);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state <= EAE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            EAE_IDLE: begin
                if (start) begin
                    state_next = dvi_overflow ? EAE_DONE : EAE_RUN;
                end
            end
            EAE_RUN: begin
                if (count == CW'(1)) begin
                    state_next = EAE_DONE;
                end
            end
            EAE_DONE: state_next = EAE_IDLE;
            default:  state_next = EAE_IDLE;
        endcase
    end

    // MUY step: add the multiplicand when the current multiplier bit is set,
    // then shift the whole {carry,hi,lo} right so the next bit reaches lo_q[0].
    always_comb begin
        mul_sum     = hi_q;
        mul_hi_next = '0;
        mul_lo_next = '0;
        if (lo_q[0]) begin
            mul_sum = hi_q + {1'b0, divisor_q};
        end
        mul_hi_next = {1'b0, mul_sum[WIDTH:1]};
        mul_lo_next = {mul_sum[0], lo_q[WIDTH-1:1]};
    end

    // DVI step: shift {R,Q} left, subtract the divisor when it fits.
    always_comb begin
        div_shift   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_diff    = div_shift - {1'b0, divisor_q};
        div_hi_next = div_shift;
        div_q_next  = {lo_q[WIDTH-2:0], 1'b0};
        if (div_shift >= {1'b0, divisor_q}) begin
            div_hi_next = div_diff;
            div_q_next  = {lo_q[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count     <= '0;
            op_q      <= EAE_MUY;
            divisor_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            ac_mul    <= '0;
            mq_mul    <= '0;
            ac_dvi    <= '0;
            mq_dvi    <= '0;
            link_dvi  <= 1'b0;
        end else begin
            case (state)
                EAE_IDLE: begin
                    if (start) begin
                        op_q      <= op;
                        divisor_q <= operand;
                        hi_q      <= {1'b0, ac_in};
                        lo_q      <= mq_in;
                        if (dvi_overflow) begin
                            count    <= '0;
                            ac_dvi   <= ac_in;
                            mq_dvi   <= mq_in;
                            link_dvi <= 1'b1;
                        end else begin
                            count <= CW'(WIDTH);
                        end
                    end
                end
                EAE_RUN: begin
                    count <= count - CW'(1);
                    if (op_q == EAE_MUY) begin
                        hi_q <= mul_hi_next;
                        lo_q <= mul_lo_next;
                    end else begin
                        hi_q <= div_hi_next;
                        lo_q <= div_q_next;
                    end
                    // Results become visible only once the final iteration lands.
                    if (last_iter) begin
                        if (op_q == EAE_MUY) begin
                            ac_mul <= mul_hi_next[WIDTH-1:0];
                            mq_mul <= mul_lo_next;
                        end else begin
                            ac_dvi   <= div_hi_next[WIDTH-1:0];
                            mq_dvi   <= div_q_next;
                            link_dvi <= 1'b0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eae_unit.sv
// Self-checking bench for eae_unit: directed PDP-8 cases plus randomized MUY/DVI
// traffic compared every cycle against an arithmetic model of the EAE.
module tb_eae_unit;
    import eae_unit_pkg::*;

    localparam int W = EAE_WIDTH;

    logic         clock = 1'b0;
    logic         resetN = 1'b0;
    logic         start = 1'b0;
    eae_op_t      op = EAE_MUY;
    logic [W-1:0] ac_in = '0;
    logic [W-1:0] mq_in = '0;
    logic [W-1:0] operand = '0;
    logic         busy, done, link_dvi;
    logic [W-1:0] ac_mul, mq_mul, ac_dvi, mq_dvi;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    eae_unit #(.WIDTH(W)) dut (
        .clock(clock), .resetN(resetN), .start(start), .op(op),
        .ac_in(ac_in), .mq_in(mq_in), .operand(operand),
        .busy(busy), .done(done),
        .ac_mul(ac_mul), .mq_mul(mq_mul),
        .ac_dvi(ac_dvi), .mq_dvi(mq_dvi), .link_dvi(link_dvi)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0o required=%0o (octal) t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy = 0, m_done = 0;
    int          m_left = 0;
    bit          m_pend_muy = 0;
    int unsigned m_pend_hi = 0, m_pend_lo = 0;
    int unsigned e_ac_mul = 0, e_mq_mul = 0, e_ac_dvi = 0, e_mq_dvi = 0;
    bit          e_link = 0;

    task automatic model_commit();
        if (m_pend_muy) begin
            e_ac_mul = m_pend_hi;
            e_mq_mul = m_pend_lo;
        end else begin
            e_ac_dvi = m_pend_hi;
            e_mq_dvi = m_pend_lo;
            e_link   = 1'b0;
        end
    endtask

    always @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            m_busy = 0; m_done = 0; m_left = 0;
            e_ac_mul = 0; e_mq_mul = 0; e_ac_dvi = 0; e_mq_dvi = 0; e_link = 0;
        end else if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                model_commit();
            end
        end else if (start) begin
            int unsigned a, m, d, prod, dividend;
            a = ac_in; m = mq_in; d = operand;
            m_busy = 1;
            if (op == EAE_MUY) begin
                prod       = m * d + a;
                m_pend_muy = 1;
                m_pend_hi  = (prod >> W) % (1 << W);
                m_pend_lo  = prod % (1 << W);
                m_left     = W;
            end else if (a >= d) begin
                m_done   = 1;
                e_link   = 1;
                e_ac_dvi = a;
                e_mq_dvi = m;
            end else begin
                dividend   = a * (1 << W) + m;
                m_pend_muy = 0;
                m_pend_hi  = dividend % d;
                m_pend_lo  = dividend / d;
                m_left     = W;
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clock) begin
        if (check_en) begin
            check("cmp_busy", 32'(busy), 32'(m_busy));
            check("cmp_done", 32'(done), 32'(m_done));
            check("cmp_ac_mul", 32'(ac_mul), e_ac_mul);
            check("cmp_mq_mul", 32'(mq_mul), e_mq_mul);
            check("cmp_ac_dvi", 32'(ac_dvi), e_ac_dvi);
            check("cmp_mq_dvi", 32'(mq_dvi), e_mq_dvi);
            check("cmp_link_dvi", 32'(link_dvi), 32'(e_link));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Issues one start, then waits (bounded) for done. lat = cycles from the
    // start edge to the done cycle; busy_n = post-edge samples with busy high.
    task automatic run_op(input eae_op_t o, input logic [W-1:0] a, input logic [W-1:0] m,
                          input logic [W-1:0] d, output int lat, output int busy_n);
        op = o; ac_in = a; mq_in = m; operand = d; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 1;
        busy_n = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clock); #1;
            lat++;
            if (busy) busy_n++;
        end
        check("done_within_budget", 32'(done), 32'd1);
        @(posedge clock); #1;
    endtask

    initial begin
        int lat, bn, pulses;
        eae_op_t ro;
        logic [W-1:0] ra, rm, rd;

        repeat (2) @(posedge clock);
        #1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_link", 32'(link_dvi), 32'd0);
        check("reset_mq_mul", 32'(mq_mul), 32'd0);
        check_en = 1'b1;
        resetN = 1'b1;
        @(posedge clock); #1;

        run_op(EAE_MUY, 12'o0000, 12'o0003, 12'o0005, lat, bn);
        check("muy_3x5_latency", lat, 13);
        check("muy_3x5_ac", 32'(ac_mul), 32'o0000);
        check("muy_3x5_mq", 32'(mq_mul), 32'o0017);

        run_op(EAE_MUY, 12'o7777, 12'o7777, 12'o7777, lat, bn);
        check("muy_max_busy_cycles", bn, 13);
        check("muy_max_ac", 32'(ac_mul), 32'o7777);
        check("muy_max_mq", 32'(mq_mul), 32'o0000);

        run_op(EAE_DVI, 12'o0000, 12'o0144, 12'o0007, lat, bn);
        check("dvi_100_7_latency", lat, 13);
        check("dvi_100_7_q", 32'(mq_dvi), 32'o0016);
        check("dvi_100_7_r", 32'(ac_dvi), 32'o0002);
        check("dvi_100_7_link", 32'(link_dvi), 32'd0);
        check("dvi_keeps_mul_mq", 32'(mq_mul), 32'o0000);

        run_op(EAE_DVI, 12'o0001, 12'o0000, 12'o0002, lat, bn);
        check("dvi_4096_2_q", 32'(mq_dvi), 32'o4000);
        check("dvi_4096_2_r", 32'(ac_dvi), 32'o0000);

        run_op(EAE_DVI, 12'o0005, 12'o1234, 12'o0005, lat, bn);
        check("dvi_ovf_latency", lat, 1);
        check("dvi_ovf_link", 32'(link_dvi), 32'd1);
        check("dvi_ovf_ac", 32'(ac_dvi), 32'o0005);
        check("dvi_ovf_mq", 32'(mq_dvi), 32'o1234);

        run_op(EAE_DVI, 12'o0000, 12'o0042, 12'o0000, lat, bn);
        check("dvi_div0_link", 32'(link_dvi), 32'd1);
        check("dvi_div0_mq", 32'(mq_dvi), 32'o0042);

        // Extra start pulses mid-run and in the DONE cycle must be ignored.
        op = EAE_MUY; ac_in = 12'o0000; mq_in = 12'o0003; operand = 12'o0005; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        mq_in = 12'o0100; operand = 12'o0100; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                pulses++;
                start = 1'b1;
            end
            @(posedge clock); #1;
            start = 1'b0;
        end
        check("restart_single_done", pulses, 1);
        check("restart_idle_after", 32'(busy), 32'd0);
        check("restart_mq_mul", 32'(mq_mul), 32'o0017);

        // Asynchronous reset in the middle of a DVI.
        op = EAE_DVI; ac_in = 12'o0000; mq_in = 12'o0144; operand = 12'o0007; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (5) @(posedge clock);
        #2;
        resetN = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_ac_mul", 32'(ac_mul), 32'd0);
        check("arst_mq_dvi", 32'(mq_dvi), 32'd0);
        check("arst_ac_dvi", 32'(ac_dvi), 32'd0);
        check("arst_link", 32'(link_dvi), 32'd0);
        @(posedge clock); #1;
        resetN = 1'b1;
        @(posedge clock); #1;
        run_op(EAE_MUY, 12'o0000, 12'o0002, 12'o0003, lat, bn);
        check("post_rst_muy_mq", 32'(mq_mul), 32'o0006);
        check("post_rst_muy_ac", 32'(ac_mul), 32'o0000);

        // Randomized traffic; the per-cycle compare checks every result.
        for (int n = 0; n < 80; n++) begin
            ro = ($urandom_range(0, 1) == 0) ? EAE_MUY : EAE_DVI;
            ra = W'($urandom);
            rm = W'($urandom);
            rd = W'($urandom);
            if (ro == EAE_DVI && $urandom_range(0, 3) != 0) begin
                if (rd == '0) rd = W'($urandom_range(1, 4095));
                ra = W'($urandom_range(0, int'(rd) - 1));
            end
            run_op(ro, ra, rm, rd, lat, bn);
            check("rand_latency", lat, (ro == EAE_DVI && ra >= rd) ? 1 : 13);
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #0;
        end

        check_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
